// File: rtl/motor_mix_pkg.sv
// Shared types and constants for the quad-X motor mixer.
package motor_mix_pkg;

    typedef enum logic [1:0] {DISARMED, SPINUP, ARMED} state_t;

    // Headroom bits so the four-term mix sum can never wrap.
    localparam int EXT_BITS = 2;

    // Per-motor {P,R,Y} signs, 1 = subtract. Index 0 is m1.
    localparam logic [3:0][2:0] MIX_SIGN = {3'b111, 3'b100, 3'b001, 3'b010};

    function automatic int ext_w(input int w);
        return w + EXT_BITS;
    endfunction

endpackage

// File: rtl/mix_desat.sv
// Stages 2-3 of the mixer: airmode shift registered, then clamp to [lo, MOTOR_MAX].
module mix_desat
    import motor_mix_pkg::*;
#(
    parameter int W         = 16,
    parameter int XW        = 18,
    parameter int MOTOR_MAX = 1000
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic signed [XW-1:0] mix [4],
    input  logic signed [W-1:0]  lo,
    output logic signed [W-1:0]  mot [4],
    output logic                 sat
);

    // Two more bits: shifting the most negative mix down by the largest
    // possible excess needs them.
    localparam int DW = XW + 2;
    localparam logic signed [DW-1:0] MAX_D = DW'(MOTOR_MAX);
    localparam logic signed [W-1:0]  MAX_W = W'(MOTOR_MAX);

    logic signed [XW-1:0] mx;
    logic signed [DW-1:0] shift;
    logic signed [DW-1:0] dsat [4];
    logic                 shifted;
    logic signed [DW-1:0] lo_d;

    always_comb begin
        mx = mix[0];
        for (int k = 1; k < 4; k++)
            if (mix[k] > mx) mx = mix[k];
        shift = '0;
        if (DW'(mx) > MAX_D) shift = DW'(mx) - MAX_D;
    end

    always_ff @(posedge clk) begin
        if (en) begin
            for (int k = 0; k < 4; k++) dsat[k] <= DW'(mix[k]) - shift;
            shifted <= (shift != '0);
        end
    end

    assign lo_d = DW'(lo);

    always_comb begin
        sat = shifted;
        for (int k = 0; k < 4; k++) begin
            if (dsat[k] > MAX_D) begin
                mot[k] = MAX_W;
                sat    = 1'b1;
            end else if (dsat[k] < lo_d) begin
                mot[k] = lo;
                sat    = 1'b1;
            end else begin
                mot[k] = W'(dsat[k]);
            end
        end
    end

endmodule

// File: rtl/motor_mixer_sat.sv
// Pipelined quad-X mixer with airmode desaturation, clamping and arm/spin-up FSM.
module motor_mixer_sat
    import motor_mix_pkg::*;
#(
    parameter int W         = 16,
    parameter int MOTOR_MIN = 0,
    parameter int MOTOR_MAX = 1000,
    parameter int IDLE      = 100,
    parameter int RAMP_STEP = 25
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic signed [W-1:0] throttle,
    input  logic signed [W-1:0] pitch,
    input  logic signed [W-1:0] roll,
    input  logic signed [W-1:0] yaw,
    input  logic                arm,
    output logic                out_valid,
    output logic signed [W-1:0] m1,
    output logic signed [W-1:0] m2,
    output logic signed [W-1:0] m3,
    output logic signed [W-1:0] m4,
    output logic                armed,
    output logic                sat
);

    localparam int XW = ext_w(W);
    localparam int FW = W + 1;
    localparam logic signed [W-1:0]  MIN_W  = W'(MOTOR_MIN);
    localparam logic signed [W-1:0]  IDLE_W = W'(IDLE);
    localparam logic signed [FW-1:0] IDLE_F = FW'(IDLE);
    localparam logic signed [FW-1:0] STEP_F = FW'(RAMP_STEP);

    state_t               state;
    logic signed [W-1:0]  fl;
    logic signed [FW-1:0] fl_inc;
    logic [3:1]           vld_pipe;

    logic signed [XW-1:0] t_x, p_x, r_x, y_x;
    logic signed [XW-1:0] mix_c [4];
    logic signed [XW-1:0] mix_q [4];
    logic signed [W-1:0]  lo_c;
    logic signed [W-1:0]  mot_c [4];
    logic                 sat_c;
    logic signed [W-1:0]  mot_q [4];
    logic                 sat_q;

    assign fl_inc = FW'(fl) + STEP_F;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DISARMED;
            fl    <= MIN_W;
        end else if (!arm) begin
            state <= DISARMED;
            fl    <= MIN_W;
        end else begin
            case (state)
                DISARMED: if (in_valid && throttle <= IDLE_W) begin
                    state <= SPINUP;
                    fl    <= MIN_W;
                end
                SPINUP: if (fl_inc >= IDLE_F) begin
                    fl    <= IDLE_W;
                    state <= ARMED;
                end else begin
                    fl <= W'(fl_inc);
                end
                default: ;
            endcase
        end
    end

    assign armed = (state == ARMED);

    assign t_x = XW'(throttle);
    assign p_x = XW'(pitch);
    assign r_x = XW'(roll);
    assign y_x = XW'(yaw);

    always_comb begin
        for (int k = 0; k < 4; k++)
            mix_c[k] = t_x
                + (MIX_SIGN[k][2] ? -p_x : p_x)
                + (MIX_SIGN[k][1] ? -r_x : r_x)
                + (MIX_SIGN[k][0] ? -y_x : y_x);
    end

    always_ff @(posedge clk) begin
        if (rst) vld_pipe <= '0;
        else     vld_pipe <= {vld_pipe[2:1], in_valid};
    end

    always_ff @(posedge clk) begin
        if (in_valid)
            for (int k = 0; k < 4; k++) mix_q[k] <= mix_c[k];
    end

    assign lo_c = (state == ARMED) ? IDLE_W : MIN_W;

    mix_desat #(.W(W), .XW(XW), .MOTOR_MAX(MOTOR_MAX)) u_desat (
        .clk (clk),
        .en  (vld_pipe[1]),
        .mix (mix_q),
        .lo  (lo_c),
        .mot (mot_c),
        .sat (sat_c)
    );

    // A low arm level forces the floor even before the state register
    // catches up, so no in-flight sample can leak a live command.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) mot_q[k] <= MIN_W;
            sat_q <= 1'b0;
        end else if (vld_pipe[2]) begin
            if (!arm || state == DISARMED) begin
                for (int k = 0; k < 4; k++) mot_q[k] <= MIN_W;
                sat_q <= 1'b0;
            end else if (state == SPINUP) begin
                for (int k = 0; k < 4; k++) mot_q[k] <= fl;
                sat_q <= 1'b0;
            end else begin
                for (int k = 0; k < 4; k++) mot_q[k] <= mot_c[k];
                sat_q <= sat_c;
            end
        end
    end

    assign out_valid = vld_pipe[3];
    assign m1  = mot_q[0];
    assign m2  = mot_q[1];
    assign m3  = mot_q[2];
    assign m4  = mot_q[3];
    assign sat = sat_q;

endmodule

// File: tb/tb_motor_mixer_sat.sv
// Scoreboard bench for motor_mixer_sat: directed samples push expectations, a monitor pops them.
module tb_motor_mixer_sat;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic signed [15:0] throttle, pitch, roll, yaw;
    logic               arm;
    logic               out_valid;
    logic signed [15:0] m1, m2, m3, m4;
    logic               armed;
    logic               sat;

    typedef struct {
        int m1, m2, m3, m4;
        int sat;
        int cyc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    motor_mixer_sat dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .throttle  (throttle),
        .pitch     (pitch),
        .roll      (roll),
        .yaw       (yaw),
        .arm       (arm),
        .out_valid (out_valid),
        .m1        (m1),
        .m2        (m2),
        .m3        (m3),
        .m4        (m4),
        .armed     (armed),
        .sat       (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int expv);
        tests++;
        if (got !== expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    // One input cycle; optionally push the expected output due 3 cycles later.
    task automatic smp(input logic a, input int t, input int p, input int r, input int y,
                       input logic ps, input int e1, input int e2, input int e3,
                       input int e4, input int es);
        exp_t x;
        arm      = a;
        in_valid = 1'b1;
        throttle = 16'(t);
        pitch    = 16'(p);
        roll     = 16'(r);
        yaw      = 16'(y);
        if (ps) begin
            x.m1 = e1; x.m2 = e2; x.m3 = e3; x.m4 = e4; x.sat = es; x.cyc = cyc + 3;
            q.push_back(x);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                e = q.pop_front();
                chk("out_cycle", cyc, e.cyc);
                chk("m1", int'(m1), e.m1);
                chk("m2", int'(m2), e.m2);
                chk("m3", int'(m3), e.m3);
                chk("m4", int'(m4), e.m4);
                chk("sat", int'(sat), e.sat);
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; arm = 1'b0;
        throttle = '0; pitch = '0; roll = '0; yaw = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m1", int'(m1), 0);
        chk("rst_m4", int'(m4), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_armed", int'(armed), 0);
        chk("rst_sat", int'(sat), 0);
        rst = 1'b0;

        // disarmed: floor regardless of throttle
        smp(0, 500, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        idle(4);

        // high throttle refuses to arm
        smp(1, 500, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        idle(2);
        chk("no_arm_high_thr", int'(armed), 0);

        // spin-up ramp, then first armed mix
        smp(1, 50, 0, 0, 0, 1, 25, 25, 25, 25, 0);
        smp(1, 200, 0, 0, 0, 1, 50, 50, 50, 50, 0);
        smp(1, 200, 0, 0, 0, 1, 75, 75, 75, 75, 0);
        smp(1, 200, 0, 0, 0, 1, 200, 200, 200, 200, 0);
        chk("armed_before_idle", int'(armed), 0);
        idle(1);
        chk("armed_at_idle", int'(armed), 1);

        // armed mixing, desaturation, clamping, extremes
        smp(1, 500, 100, 50, 20, 1, 570, 630, 470, 330, 0);
        smp(1, 950, 100, 0, 0, 1, 1000, 1000, 800, 800, 1);
        smp(1, 100, -80, 0, 0, 1, 100, 100, 180, 180, 1);
        smp(1, 32767, 32767, 32767, 32767, 1, 1000, 1000, 1000, 100, 1);
        smp(1, -32768, -32768, -32768, -32768, 1, 100, 100, 100, 1000, 1);
        idle(4);

        // drop arm with samples in flight
        smp(1, 500, 100, 50, 20, 1, 0, 0, 0, 0, 0);
        smp(1, 500, 100, 50, 20, 1, 0, 0, 0, 0, 0);
        smp(0, 500, 100, 50, 20, 1, 0, 0, 0, 0, 0);
        chk("armed_after_drop", int'(armed), 0);
        idle(4);

        // re-arm, then reset mid-stream
        smp(1, 50, 0, 0, 0, 1, 25, 25, 25, 25, 0);
        idle(6);
        chk("rearmed", int'(armed), 1);
        smp(1, 500, 0, 0, 0, 1, 500, 500, 500, 500, 0);
        smp(1, 500, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        smp(1, 500, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_m1", int'(m1), 0);
        chk("mid_rst_m3", int'(m3), 0);
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_armed", int'(armed), 0);
        rst = 1'b0;
        idle(6);

        chk("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/motor_mixer_sat.md
# motor_mixer_sat

Pipelined, parametrised quad-X motor mixer with airmode desaturation, output clamping and an arm/spin-up state machine. It sits between the attitude PID outputs and the per-motor PWM/DShot generators. It replaces the purely combinational mixer with registered, saturation-safe motor commands. Motors are held at a safe floor whenever the craft is disarmed.

## Interface
- W, 16: signed width of all command inputs and motor outputs
- MOTOR_MIN, 0: absolute lower motor command; output when disarmed
- MOTOR_MAX, 1000: absolute upper motor command
- IDLE, 100: armed idle floor (MOTOR_MIN ≤ IDLE < MOTOR_MAX)
- RAMP_STEP, 25: spin-up increment per clock, > 0
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  command sample strobe
- throttle, pitch, roll, yaw  in  W each  signed commands
- arm  in  1  arm request level
- out_valid  out  1  motor commands updated this cycle
- m1, m2, m3, m4  out  W each  signed motor commands
- armed  out  1  high in ARMED state only
- sat  out  1  desaturation shift or clamp applied to current output

## Operation
- Mix, stage 1 (registered on in_valid):
  - m1 = T+P−R+Y
  - m2 = T+P+R−Y
  - m3 = T−P+R+Y
  - m4 = T−P−R−Y
  - Computed in W+2 bits with sign extension, so no wrap-around is possible.
- Desaturation, stage 2:
  - mx = max(m1..m4).
  - If mx > MOTOR_MAX, subtract (mx − MOTOR_MAX) from all four, so attitude differentials are preserved.
- Clamp, stage 3:
  - Each value is clamped to [lo, MOTOR_MAX], where lo = IDLE in ARMED.
  - Result is truncated to W bits; the clamp guarantees it fits.
  - sat = 1 if the stage-2 shift was non-zero or any clamp bound was hit.
- FSM (states DISARMED, SPINUP, ARMED), with a floor register fl:
  - DISARMED → SPINUP: when arm=1, in_valid=1 and throttle ≤ IDLE on the same cycle. fl loads MOTOR_MIN at the transition.
  - SPINUP: each cycle fl ← min(fl+RAMP_STEP, IDLE). Move to ARMED on the cycle fl becomes IDLE.
  - Any state → DISARMED on the first cycle arm=0. Disarm takes priority over all other transitions.
  - arm=1 with throttle > IDLE does not arm. A new arm attempt requires remaining in DISARMED; no edge detection.
- Output selection, on the cycle stage 3 is valid and based on the current state:
  - DISARMED: all four = MOTOR_MIN, sat=0.
  - SPINUP: all four = fl, sat=0.
  - ARMED: clamped mix.

## Timing
- Reset (all synchronous, one cycle):
  - m1..m4 = MOTOR_MIN; out_valid, armed and sat = 0.
  - State = DISARMED; fl = MOTOR_MIN; all pipeline valids cleared.
- Latency: in_valid at cycle N gives out_valid=1 at cycle N+3, for one cycle per accepted sample.
- Throughput: one sample per clock. There is no backpressure and in_valid may be held high continuously.
- m1..m4 and sat hold their value between out_valid pulses. armed reflects the FSM state register directly.
- Disarm mid-pipeline: samples in flight emerge with MOTOR_MIN values. Disarm reaches the outputs no later than the next out_valid.
- Reset mid-operation flushes the pipeline; no out_valid occurs for samples accepted before reset.
- Equal maxima across motors are valid: the single shift applies to all four.

## Structure
- Package motor_mix_pkg:
  - state enum (DISARMED, SPINUP, ARMED)
  - mix sign constants, per motor {P,R,Y} signs: m1 {+,−,+}, m2 {+,+,−}, m3 {−,+,+}, m4 {−,−,−}
  - extended-width localparam W+2
- Sub-module mix_desat holds stages 2–3: max-find, shift and clamp, parametrised on W, bounds and lo.
- FSM, floor ramp and stage 1 live in the top module.

## Test plan
Defaults: W=16, MIN=0, MAX=1000, IDLE=100, STEP=25.

1. Disarmed, T=500, P=R=Y=0, in_valid pulse at cycle 0 → out_valid at cycle 3, m1..m4=0, armed=0, sat=0.
2. arm=1 with T=500 → stays DISARMED. arm=1 with T=50 → SPINUP; continuous in_valid gives floors 25, 50, 75, 100, then armed=1.
3. Armed, T=500, P=100, R=50, Y=20 → m1=570, m2=630, m3=470, m4=330, sat=0.
4. Armed, T=950, P=100, R=Y=0 → raw 1050/1050/850/850 → m1=m2=1000, m3=m4=800, sat=1.
5. Armed, T=100, P=−80 → m1=m2=100 (clamped from 20), m3=m4=180, sat=1. Extremes T=32767, P=R=Y=32767 → no wrap, all outputs within [100, 1000].
6. Drop arm with 3 samples in flight → all three outputs are MOTOR_MIN and armed=0 next cycle. Assert rst mid-stream → next cycle all outputs are reset values and no stale out_valid.
